// File: rtl/multicycle_control.sv
// Moore control FSM for a five-class multicycle MIPS-style datapath (lw/sw, R-type, addi, beq, j)
// sharing a single memory port that may stall via mem_ready.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zf,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       trap
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StIExec   = 4'd10,
    StIWb     = 4'd11,
    StTrap    = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e state_q, state_d;

  // Branch resolution is done in the datapath as pc_write_cond & zf.
  logic unused_zf;
  assign unused_zf = zf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;

    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        unique case (opcode)
          OpRType:     state_d = StRExec;
          OpLw, OpSw:  state_d = StMemAddr;
          OpBeq:       state_d = StBranch;
          OpJ:         state_d = StJump;
          OpAddi:      state_d = StIExec;
          default:     state_d = StTrap;
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = StFetch;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = StFetch;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // Reset is synchronous for state, but enables must be quiet in the reset cycle itself.
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
    end
  end

  assign state = state_q;
  assign trap  = (state_q == StTrap);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: an instruction-level model expands each instruction into its expected per-cycle
// state trace; a compare process checks every DUT output each cycle against a per-state table.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zf;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       trap;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zf            (zf),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .trap          (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic       rs;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] seq_st[$];
  logic       seq_mr[$];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Expected outputs for a state:
  // {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
  //  mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[2:0], pc_source[1:0], trap}
  function automatic logic [17:0] exp_out(logic [3:0] st, logic mr, logic rs);
    logic pw = 0, pwc = 0, irw = 0, mrd = 0, mwr = 0, iod = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
    logic [1:0] sb = 0;
    logic [2:0] op = 0;
    logic [1:0] ps = 0;
    logic       tr = 0;
    case (st)
      4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin sa = 1; op = 3'b010; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; op = 3'b001; pwc = 1; ps = 2'b01; end
      4'd9:  begin pw = 1; ps = 2'b10; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: rw = 1;
      4'd12: tr = 1;
      default: ;
    endcase
    if (!rs) begin
      pw = 0; pwc = 0; irw = 0; mrd = 0; mwr = 0; rw = 0;
    end
    return {pw, pwc, irw, mrd, mwr, iod, rw, rd, m2r, sa, sb, op, ps, tr};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("outputs", 32'({pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                          reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                          pc_source, trap}), 32'(exp_out(e.st, e.mr, e.rs)));
      chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
      chk("pc_excl", 32'(pc_write & pc_write_cond), 32'd0);
    end
  end

  function automatic void push(logic [3:0] st, logic mr);
    seq_st.push_back(st);
    seq_mr.push_back(mr);
  endfunction

  // Instruction-level model: expected state per cycle with the mem_ready value to drive.
  function automatic void build_seq(logic [5:0] op, int fw, int mw, int hold);
    seq_st.delete();
    seq_mr.delete();
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'($urandom));
    case (op)
      6'b100011: begin
        push(4'd2, 1'($urandom));
        for (int i = 0; i < mw; i++) push(4'd3, 1'b0);
        push(4'd3, 1'b1);
        push(4'd4, 1'($urandom));
      end
      6'b101011: begin
        push(4'd2, 1'($urandom));
        for (int i = 0; i < mw; i++) push(4'd5, 1'b0);
        push(4'd5, 1'b1);
      end
      6'b000000: begin push(4'd6, 1'($urandom)); push(4'd7, 1'($urandom)); end
      6'b001000: begin push(4'd10, 1'($urandom)); push(4'd11, 1'($urandom)); end
      6'b000100: push(4'd8, 1'($urandom));
      6'b000010: push(4'd9, 1'($urandom));
      default:   for (int i = 0; i < hold; i++) push(4'd12, 1'($urandom));
    endcase
  endfunction

  // abort >= 0: drive rst_n low in that step, ending the instruction there.
  task automatic run(string name, logic [5:0] op, int fw, int mw, int hold, logic zfv, int abort,
                     int exp_len, logic [63:0] exp_pack);
    logic [63:0] pack = '0;
    logic [63:0] nib;
    exp_t e;
    build_seq(op, fw, mw, hold);
    for (int i = 0; i < seq_st.size() && i < 16; i++) begin
      nib = {60'd0, seq_st[i]};
      pack |= nib << (4 * i);
    end
    chk({name, "_len"}, 32'(seq_st.size()), 32'(exp_len));
    chk({name, "_trace_lo"}, pack[31:0], exp_pack[31:0]);
    chk({name, "_trace_hi"}, pack[63:32], exp_pack[63:32]);
    opcode = op;
    for (int i = 0; i < seq_st.size(); i++) begin
      rst_n     = (i == abort) ? 1'b0 : 1'b1;
      mem_ready = seq_mr[i];
      zf        = zfv;
      e.st = seq_st[i];
      e.mr = seq_mr[i];
      e.rs = rst_n;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (i == abort) break;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    zf        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    e.st = 4'd0; e.mr = 1'b1; e.rs = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run("lw",       6'b100011, 0, 0, 0,  1'b0, -1, 5,  64'h43210);
    run("sw_wait2", 6'b101011, 0, 2, 0,  1'b1, -1, 6,  64'h555210);
    run("r_fwait3", 6'b000000, 3, 0, 0,  1'b0, -1, 7,  64'h7610000);
    run("addi",     6'b001000, 0, 0, 0,  1'b1, -1, 4,  64'hBA10);
    run("beq_z1",   6'b000100, 0, 0, 0,  1'b1, -1, 3,  64'h810);
    run("beq_z0",   6'b000100, 0, 0, 0,  1'b0, -1, 3,  64'h810);
    run("j",        6'b000010, 0, 0, 0,  1'b1, -1, 3,  64'h910);
    run("lw_waits", 6'b100011, 1, 2, 0,  1'b0, -1, 8,  64'h43332100);
    run("sw",       6'b101011, 0, 0, 0,  1'b0, -1, 4,  64'h5210);
    run("r_rst_wb", 6'b000000, 0, 0, 0,  1'b1, 3,  4,  64'h7610);
    run("trap_ff",  6'b111111, 0, 0, 11, 1'b0, 12, 13, 64'hCCCCCCCCCCC10);
    run("trap_03",  6'b000011, 0, 0, 2,  1'b1, 3,  4,  64'hCC10);
    run("lw_after", 6'b100011, 2, 1, 0,  1'b1, -1, 8,  64'h43321000);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have opcode, input, 6 bits: Instruction[31:26] from the instruction register.
REQ-004 SHALL have zf, input, 1 bit: ALU zero flag.
REQ-005 SHALL have mem_ready, input, 1 bit: shared memory completes the current access this cycle.
REQ-006 SHALL have pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a as outputs, 1 bit each: datapath enables and selects.
REQ-007 SHALL have alu_src_b, output, 2 bits: 00 = B reg, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
REQ-008 SHALL have alu_op, output, 3 bits: 000 = add, 001 = sub, 010 = decode funct.
REQ-009 SHALL have pc_source, output, 2 bits: 00 = ALU result, 01 = ALUOut, 10 = jump address.
REQ-010 SHALL have state, output, 4 bits (current state code) and trap, output, 1 bit (illegal opcode).

Function
REQ-011 SHALL implement a Moore FSM; state codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12.
REQ-012 SHALL, in FETCH: assert mem_read; set i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00; gate ir_write=1 and pc_write=1 with mem_ready; stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-013 SHALL, in DECODE: set alu_src_a=0, alu_src_b=11, alu_op=000; assert no enables.
REQ-014 SHALL, in DECODE, branch on opcode: 000000 -> R_EXEC; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> I_EXEC; any other opcode -> TRAP.
REQ-015 SHALL, in MEM_ADDR: set alu_src_a=1, alu_src_b=10, alu_op=000; go to MEM_RD for 100011, else MEM_WR.
REQ-016 SHALL, in MEM_RD: set mem_read=1, i_or_d=1; hold while mem_ready=0; go to MEM_WB on mem_ready=1.
REQ-017 SHALL, in MEM_WR: set mem_write=1, i_or_d=1; hold while mem_ready=0; go to FETCH on mem_ready=1.
REQ-018 SHALL, in MEM_WB: set reg_write=1, reg_dst=0, mem_to_reg=1; go to FETCH.
REQ-019 SHALL, in R_EXEC: set alu_src_a=1, alu_src_b=00, alu_op=010; go to R_WB.
REQ-020 SHALL, in R_WB: set reg_write=1, reg_dst=1, mem_to_reg=0; go to FETCH.
REQ-021 SHALL, in BRANCH: set alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01; go to FETCH.
REQ-022 SHALL, in JUMP: set pc_write=1, pc_source=10; go to FETCH.
REQ-023 SHALL, in I_EXEC: set alu_src_a=1, alu_src_b=10, alu_op=000; go to I_WB.
REQ-024 SHALL, in I_WB: set reg_write=1, reg_dst=0, mem_to_reg=0; go to FETCH.
REQ-025 SHALL, in TRAP: hold trap=1 with all enables 0; leave TRAP only via reset.
REQ-026 SHALL drive every output not listed for a state to 0.
REQ-027 SHALL never assert mem_read and mem_write in the same cycle, nor more than one of pc_write/pc_write_cond.
REQ-028 SHALL take the following cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds exactly one cycle.
REQ-029 SHALL leave zf to the datapath (pc_write_cond AND zf); the FSM path SHALL NOT depend on zf.

Reset
REQ-030 SHALL load state=FETCH on any rising edge with rst_n=0, including mid-instruction and mid-wait; trap SHALL clear.
REQ-031 SHALL force all enables (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) to 0 combinationally while rst_n=0.
REQ-032 SHALL, on the first edge after rst_n returns high, be in FETCH with mem_read=1.

Verification
REQ-033 SHALL cover lw (opcode 100011), mem_ready always 1: state sequence 0,1,2,3,4,0; reg_write=1 only in state 4, with mem_to_reg=1.
REQ-034 SHALL cover sw with mem_ready=0 for 2 cycles in MEM_WR: state sequence 0,1,2,5,5,5,0; mem_write high for all 3 cycles; 6 cycles total.
REQ-035 SHALL cover beq: states 0,1,8,0; pc_write_cond=1 and alu_op=001 in state 8; pc_write=0 there regardless of zf.
REQ-036 SHALL cover opcode 111111: DECODE -> TRAP; trap=1 held for 10 cycles; rst_n=0 for 1 edge -> state=0, trap=0.
REQ-037 SHALL cover FETCH with mem_ready=0 for 3 cycles: ir_write=0 and pc_write=0 during the wait; both =1 in the ready cycle; then DECODE.
REQ-038 SHALL cover rst_n=0 asserted in R_WB: reg_write=0 in that cycle; state=FETCH next edge; no register write occurs.
